// File: rtl/trigger_pkg.sv
// Shared types and constants for the burst trigger sequencer.
package trigger_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int NUM_W_DEFAULT = 16;
    localparam int MIN_WIDTH     = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/trigger_phase_cnt.sv
// Phase counter shared by the DELAY, HIGH and LOW phases; match flags the last cycle of a phase.
module trigger_phase_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             match
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign match = (count_q == terminal);

endmodule

// File: rtl/trigger_sequencer.sv
// Programmable burst trigger: optional start delay, then cfg_num pulses of programmable width and period.
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int NUM_W = NUM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_num,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_W_CNT = CNT_W'(MIN_WIDTH);
    localparam logic [NUM_W-1:0] ONE_NUM   = NUM_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] eff_width;
    logic [CNT_W-1:0] eff_low;
    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_terminal;
    logic [CNT_W-1:0] phase_count;
    logic             phase_match;

    // period > w is the same test as max(period, w+1) done at CNT_W+1 bits, without ever forming w+1
    always_comb begin
        eff_width = (cfg_width < MIN_W_CNT) ? MIN_W_CNT : cfg_width;
        eff_low   = (cfg_period > eff_width) ? (cfg_period - eff_width) : ONE_CNT;
    end

    always_comb begin
        unique case (state_q)
            ST_DELAY: cnt_terminal = delay_q - ONE_CNT;
            ST_HIGH:  cnt_terminal = width_q - ONE_CNT;
            ST_LOW:   cnt_terminal = low_q - ONE_CNT;
            default:  cnt_terminal = '0;
        endcase
    end

    trigger_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_terminal),
        .count    (phase_count),
        .match    (phase_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            delay_q <= '0;
            width_q <= '0;
            low_q   <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            width_q <= width_d;
            low_q   <= low_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        width_d   = width_q;
        low_d     = low_q;
        num_d     = num_q;
        idx_d     = idx_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        if (state_q != ST_IDLE && abort) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_clear = 1'b1;
                    if (start && !abort) begin
                        delay_d = cfg_delay;
                        width_d = eff_width;
                        low_d   = eff_low;
                        num_d   = cfg_num;
                        idx_d   = '0;
                        if (cfg_num == '0) begin
                            state_d = ST_DONE;
                        end else if (cfg_delay == '0) begin
                            state_d = ST_HIGH;
                        end else begin
                            state_d = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (phase_match) begin
                        state_d   = ST_HIGH;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_match) begin
                        cnt_clear = 1'b1;
                        state_d   = (idx_q == num_q - ONE_NUM) ? ST_DONE : ST_LOW;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_match) begin
                        state_d   = ST_HIGH;
                        idx_d     = idx_q + ONE_NUM;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state register
    always_comb begin
        tx_d   = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_idx = idx_q;

    phase_count_in_range: assert property (
        @(posedge clk) disable iff (!rst)
        (state_q inside {ST_DELAY, ST_HIGH, ST_LOW}) |-> (phase_count <= cnt_terminal)
    );

endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomized bench for trigger_sequencer, checked every cycle against a timeline model of the burst.
module tb_trigger_sequencer;

    localparam int CNT_W = 32;
    localparam int NUM_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_period;
    logic [NUM_W-1:0] cfg_num;
    logic             tx;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_idx;

    int check_count = 0;
    int fail_count  = 0;

    bit              m_active = 1'b0;
    longint unsigned m_n, m_delay, m_width, m_period, m_num, m_done_at;
    longint unsigned m_idx = 0;
    bit              exp_tx, exp_busy, exp_done;

    trigger_sequencer #(
        .CNT_W (CNT_W),
        .NUM_W (NUM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_num    (cfg_num),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Burst as a timeline: pulse k rises at offset delay+k*period and stays high for width cycles
    task automatic modelEdge(input logic s, input logic a);
        longint unsigned k;
        if (!m_active) begin
            if (s && !a) begin
                m_delay   = cfg_delay;
                m_width   = (cfg_width == 0) ? 1 : cfg_width;
                m_period  = (cfg_period > m_width) ? cfg_period : m_width + 1;
                m_num     = cfg_num;
                m_done_at = (m_num == 0) ? 0 : m_delay + (m_num - 1) * m_period + m_width;
                m_active  = 1'b1;
                m_n       = 0;
                m_idx     = 0;
            end
        end else if (a) begin
            m_active = 1'b0;
        end else begin
            m_n++;
            if (m_n > m_done_at) m_active = 1'b0;
        end
        exp_tx   = 1'b0;
        exp_busy = m_active;
        exp_done = 1'b0;
        if (m_active) begin
            exp_done = (m_n == m_done_at);
            if (m_num != 0 && m_n >= m_delay) begin
                k      = (m_n - m_delay) / m_period;
                exp_tx = (k < m_num) && (((m_n - m_delay) % m_period) < m_width);
                m_idx  = (k < m_num) ? k : m_num - 1;
            end else begin
                m_idx = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
        @(posedge clk);
        #1;
        modelEdge(s, a);
        checkOutput("tx", 32'(tx), 32'(exp_tx));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("done", 32'(done), 32'(exp_done));
        checkOutput("pulse_idx", 32'(pulse_idx), 32'(m_idx));
    endtask

    task automatic setCfg(input int d, input int w, input int p, input int n);
        cfg_delay  = CNT_W'(d);
        cfg_width  = CNT_W'(w);
        cfg_period = CNT_W'(p);
        cfg_num    = NUM_W'(n);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx"}, 32'(tx), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_idx"}, 32'(pulse_idx), 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        setCfg(0, 0, 0, 0);
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic burst, with starts during HIGH and DONE and a cfg change mid-burst
        setCfg(3, 2, 5, 3);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 6) setCfg(1, 7, 9, 5);
            applyStimulus((i == 3) || (i == 15), 1'b0);
        end

        // Clamped width/period, then an empty burst
        setCfg(0, 0, 0, 2);
        applyStimulus(1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0);
        setCfg(2, 3, 4, 0);
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Abort beats a simultaneous start in IDLE
        setCfg(1, 1, 3, 2);
        applyStimulus(1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0);

        // Abort in the second LOW phase, then a full burst
        setCfg(3, 2, 5, 3);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, (i == 10));
        applyStimulus(1'b1, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0);

        // Asynchronous reset while HIGH
        applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_reset_tx", 32'(tx), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkResetValues("async_reset");
        m_active = 1'b0;
        m_idx    = 0;
        @(negedge clk);
        rst = 1'b1;

        // Long pulse with a near-maximum period
        cfg_delay  = 32'd2;
        cfg_width  = 32'd1000;
        cfg_period = 32'hFFFF_FFFF;
        cfg_num    = 16'd2;
        applyStimulus(1'b1, 1'b0);
        repeat (1100) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic s, a;
            if (!m_active || $urandom_range(0, 9) == 0) begin
                setCfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 8)), int'($urandom_range(0, 4)));
            end
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            applyStimulus(s, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
